// File: rtl/sw_port_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one byte-serial output among NUM_PORTS inputs.
// A granted packet runs to its last byte or is aborted after MAX_GAP idle cycles from the owner.
module sw_port_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned MAX_GAP   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_PORTS-1:0] data_in,
    input  logic [NUM_PORTS-1:0]   sw_enable_in,
    input  logic [NUM_PORTS-1:0]   last_in,
    output logic [NUM_PORTS-1:0]   read_out,
    output logic [7:0]             data_out,
    output logic                   sw_enable_out,
    output logic                   last_out,
    input  logic                   out_busy_in,
    output logic [NUM_PORTS-1:0]   grant_out,
    output logic                   pkt_abort
);

    localparam int unsigned IdxW = $clog2(NUM_PORTS);
    localparam int unsigned GapW = $clog2(MAX_GAP + 1);
    localparam logic [IdxW:0]   NumP    = (IdxW + 1)'(NUM_PORTS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_PORTS - 1);
    localparam logic [GapW-1:0] GapMax  = GapW'(MAX_GAP);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e                r_state, w_state_nxt;
    logic [IdxW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [IdxW-1:0]       r_owner, w_owner_nxt;
    logic [NUM_PORTS-1:0]  r_grant, w_grant_nxt;
    logic [GapW-1:0]       r_gap_cnt, w_gap_cnt_nxt;
    logic                  r_pkt_abort, w_pkt_abort_nxt;

    logic [2*NUM_PORTS-1:0] w_req_dbl;
    logic                   w_req_found;
    logic [IdxW-1:0]        w_req_off;
    logic [IdxW:0]          w_req_sum;
    logic [IdxW-1:0]        w_req_idx;
    logic [7:0]             w_own_data;
    logic                   w_own_en;
    logic                   w_own_last;
    logic [IdxW-1:0]        w_owner_inc;
    logic [GapW-1:0]        w_gap_inc;

    // Rotate requests so bit 0 is rr_ptr, take the first set bit, then rotate the index back.
    always_comb begin
        w_req_dbl   = {sw_enable_in, sw_enable_in} >> r_rr_ptr;
        w_req_found = 1'b0;
        w_req_off   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!w_req_found && w_req_dbl[k]) begin
                w_req_found = 1'b1;
                w_req_off   = IdxW'(k);
            end
        end
        w_req_sum = {1'b0, r_rr_ptr} + {1'b0, w_req_off};
        if (w_req_sum >= NumP) begin
            w_req_sum = w_req_sum - NumP;
        end
        w_req_idx = w_req_sum[IdxW-1:0];
    end

    always_comb begin
        w_own_data = 8'h00;
        w_own_en   = 1'b0;
        w_own_last = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (r_owner == IdxW'(k)) begin
                w_own_data = data_in[8*k +: 8];
                w_own_en   = sw_enable_in[k];
                w_own_last = last_in[k];
            end
        end
    end

    assign w_owner_inc = (r_owner == LastIdx) ? '0 : r_owner + 1'b1;
    assign w_gap_inc   = r_gap_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_grant     <= '0;
            r_gap_cnt   <= '0;
            r_pkt_abort <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_grant     <= w_grant_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_pkt_abort <= w_pkt_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_owner_nxt     = r_owner;
        w_grant_nxt     = r_grant;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_pkt_abort_nxt = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_req_found) begin
                    w_state_nxt   = StXfer;
                    w_owner_nxt   = w_req_idx;
                    w_gap_cnt_nxt = '0;
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        w_grant_nxt[k] = (w_req_idx == IdxW'(k));
                    end
                end
            end
            StXfer: begin
                if (w_own_en && w_own_last && !out_busy_in) begin
                    w_state_nxt   = StIdle;
                    w_rr_ptr_nxt  = w_owner_inc;
                    w_grant_nxt   = '0;
                    w_gap_cnt_nxt = '0;
                end else if (w_own_en) begin
                    // Any valid byte from the owner restarts the gap window, stalled or not.
                    w_gap_cnt_nxt = '0;
                end else if (w_gap_inc == GapMax) begin
                    w_state_nxt     = StIdle;
                    w_rr_ptr_nxt    = w_owner_inc;
                    w_grant_nxt     = '0;
                    w_gap_cnt_nxt   = '0;
                    w_pkt_abort_nxt = 1'b1;
                end else begin
                    w_gap_cnt_nxt = w_gap_inc;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_comb begin
        read_out      = '1;
        data_out      = 8'h00;
        sw_enable_out = 1'b0;
        last_out      = 1'b0;
        if (r_state == StXfer) begin
            read_out      = ~r_grant | {NUM_PORTS{out_busy_in}};
            data_out      = w_own_data;
            sw_enable_out = w_own_en;
            last_out      = w_own_en & w_own_last;
        end
    end

    assign grant_out = r_grant;
    assign pkt_abort = r_pkt_abort;

endmodule

// File: tb/tb_sw_port_arbiter.sv
// Scoreboard bench for sw_port_arbiter: per-port byte sources feed the DUT, a monitor checks
// every forwarded byte, grant order, idle bubbles and aborts against queued expectations.
module tb_sw_port_arbiter;

    localparam int NP = 4;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } ent_t;

    logic            clk;
    logic            rst;
    logic [8*NP-1:0] data_in;
    logic [NP-1:0]   sw_enable_in;
    logic [NP-1:0]   last_in;
    logic [NP-1:0]   read_out;
    logic [7:0]      data_out;
    logic            sw_enable_out;
    logic            last_out;
    logic            out_busy_in;
    logic [NP-1:0]   grant_out;
    logic            pkt_abort;

    ent_t          src_q[NP][$];
    ent_t          exp_q[NP][$];
    int            order_q[$];
    logic [NP-1:0] accepted;
    int            xfer_cnt[NP];
    int            abort_cnt;
    int            n_checks;
    int            n_errors;

    sw_port_arbiter #(
        .NUM_PORTS(NP),
        .MAX_GAP  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .sw_enable_in (sw_enable_in),
        .last_in      (last_in),
        .read_out     (read_out),
        .data_out     (data_out),
        .sw_enable_out(sw_enable_out),
        .last_out     (last_out),
        .out_busy_in  (out_busy_in),
        .grant_out    (grant_out),
        .pkt_abort    (pkt_abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NP; i++) begin
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        end
        return order_q.size() == 0;
    endfunction

    task automatic push_byte(input int p, input logic [7:0] d, input logic l, input int g);
        ent_t e;
        e.data = d;
        e.last = l;
        e.gap  = g;
        src_q[p].push_back(e);
        exp_q[p].push_back(e);
    endtask

    task automatic push_pkt(input int p, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            push_byte(p, 8'(base + k), (k == n - 1), 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(all_empty() && grant_out == '0 && !sw_enable_out) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_completes"}, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_xfers(input string name, input int p, input int target, input int budget);
        int n;
        n = 0;
        while (xfer_cnt[p] < target && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_first_byte"}, 32'(n < budget), 32'd1);
    endtask

    // Sources: present the queue head, pop it after the DUT accepted it on the previous cycle.
    initial begin
        sw_enable_in = '0;
        data_in      = '0;
        last_in      = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NP; i++) begin
                if (accepted[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                sw_enable_in[i]     = 1'b0;
                last_in[i]          = 1'b0;
                data_in[8*i +: 8]   = 8'h00;
                if (src_q[i].size() > 0) begin
                    ent_t e;
                    e = src_q[i][0];
                    if (e.gap > 0) begin
                        e.gap--;
                        src_q[i][0] = e;
                    end else begin
                        sw_enable_in[i]   = 1'b1;
                        data_in[8*i +: 8] = e.data;
                        last_in[i]        = e.last;
                    end
                end
            end
        end
    end

    // Monitor: checks every output transfer and grant event against the expectation queues.
    initial begin
        logic [NP-1:0] prev_grant;
        logic          expect_idle;
        ent_t          e;
        int            own;
        int            w;
        accepted    = '0;
        prev_grant  = '0;
        expect_idle = 1'b0;
        abort_cnt   = 0;
        for (int i = 0; i < NP; i++) xfer_cnt[i] = 0;
        forever begin
            @(negedge clk);
            accepted = '0;
            if (!rst) begin
                if (pkt_abort) abort_cnt++;
                if (expect_idle) begin
                    chk("bubble_after_last", 32'(grant_out), 32'd0);
                    expect_idle = 1'b0;
                end
                if (prev_grant == '0 && grant_out != '0) begin
                    if (order_q.size() == 0) begin
                        chk("unexpected_grant", 32'(grant_out), 32'd0);
                    end else begin
                        w = order_q.pop_front();
                        chk("grant_order", 32'(grant_out), 32'd1 << w);
                    end
                end
                if (sw_enable_out && !out_busy_in) begin
                    own = onehot_idx(grant_out);
                    if (exp_q[own].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL extra_byte: port %0d sent %02h, expected no byte", own,
                                 data_out);
                    end else begin
                        e = exp_q[own].pop_front();
                        chk($sformatf("data_p%0d", own), 32'(data_out), 32'(e.data));
                        chk($sformatf("last_p%0d", own), 32'(last_out), 32'(e.last));
                        xfer_cnt[own]++;
                        if (last_out) expect_idle = 1'b1;
                    end
                end
                accepted = sw_enable_in & ~read_out;
            end else begin
                expect_idle = 1'b0;
            end
            prev_grant = grant_out;
        end
    end

    initial begin
        int base;
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        out_busy_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant_out), 32'd0);
        chk("rst_read_out", 32'(read_out), 32'hF);
        chk("rst_sw_enable_out", 32'(sw_enable_out), 32'd0);
        chk("rst_last_out", 32'(last_out), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_pkt_abort", 32'(pkt_abort), 32'd0);

        // All four ports at once straight after reset.
        tick();
        rst = 1'b0;
        for (int p = 0; p < NP; p++) begin
            order_q.push_back(p);
            push_pkt(p, 8'(8'h10 * (p + 1)), 2);
        end
        wait_idle("all_ports", 200);

        // rr_ptr back at 0: port 0 beats port 2, then 2.
        tick();
        order_q.push_back(0);
        order_q.push_back(2);
        push_pkt(0, 8'h50, 2);
        push_pkt(2, 8'h60, 2);
        wait_idle("rr_0_2", 100);

        // rr_ptr now 3: search wraps to port 0 ahead of port 1.
        tick();
        order_q.push_back(0);
        order_q.push_back(1);
        push_pkt(0, 8'h70, 2);
        push_pkt(1, 8'h80, 2);
        wait_idle("rr_wrap", 100);

        // Single port 2 packet with cycle-exact checks.
        tick();
        order_q.push_back(2);
        push_pkt(2, 8'hA1, 3);
        @(negedge clk);
        chk("t1_grant_req_cycle", 32'(grant_out), 32'd0);
        chk("t1_read_out_idle", 32'(read_out), 32'hF);
        @(negedge clk);
        chk("t1_grant", 32'(grant_out), 32'b0100);
        chk("t1_byte1", 32'(data_out), 32'hA1);
        chk("t1_read_out_b1", 32'(read_out), 32'b1011);
        chk("t1_last_b1", 32'(last_out), 32'd0);
        @(negedge clk);
        chk("t1_byte2", 32'(data_out), 32'hA2);
        chk("t1_read_out_b2", 32'(read_out), 32'b1011);
        @(negedge clk);
        chk("t1_byte3", 32'(data_out), 32'hA3);
        chk("t1_last_b3", 32'(last_out), 32'd1);
        @(negedge clk);
        chk("t1_grant_after", 32'(grant_out), 32'd0);
        wait_idle("single_port", 50);

        // Backpressure for two cycles on byte 2 of a 4-byte packet.
        tick();
        order_q.push_back(0);
        base = xfer_cnt[0];
        push_pkt(0, 8'hB1, 4);
        wait_xfers("bp", 0, base + 1, 50);
        out_busy_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_read_out_busy", 32'(read_out[0]), 32'd1);
            chk("bp_hold_byte2", 32'(data_out), 32'hB2);
            tick();
        end
        out_busy_in = 1'b0;
        wait_idle("backpressure", 50);
        chk("bp_transfer_count", 32'(xfer_cnt[0] - base), 32'd4);

        // Gap timeout: port 1 sends one byte then goes silent.
        tick();
        order_q.push_back(1);
        base = xfer_cnt[1];
        push_byte(1, 8'hC1, 1'b0, 0);
        wait_xfers("abort", 1, base + 1, 50);
        order_q.push_back(2);
        order_q.push_back(0);
        push_pkt(2, 8'hD1, 2);
        push_pkt(0, 8'hE1, 2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("gap_no_abort_yet", 32'(pkt_abort), 32'd0);
            chk("gap_grant_held", 32'(grant_out), 32'b0010);
        end
        @(negedge clk);
        chk("abort_pulse", 32'(pkt_abort), 32'd1);
        chk("abort_grant_clear", 32'(grant_out), 32'd0);
        @(negedge clk);
        chk("abort_one_cycle", 32'(pkt_abort), 32'd0);
        chk("abort_next_grant", 32'(grant_out), 32'b0100);
        wait_idle("gap_abort", 100);
        chk("abort_count", 32'(abort_cnt), 32'd1);

        // Short gap of 3 cycles is tolerated.
        tick();
        order_q.push_back(3);
        push_byte(3, 8'hF1, 1'b0, 0);
        push_byte(3, 8'hF2, 1'b0, 3);
        push_byte(3, 8'hF3, 1'b1, 0);
        wait_idle("short_gap", 50);
        chk("short_gap_no_abort", 32'(abort_cnt), 32'd1);

        // Reset in the middle of port 3's packet.
        tick();
        order_q.push_back(3);
        base = xfer_cnt[3];
        push_pkt(3, 8'h31, 3);
        wait_xfers("mid_rst", 3, base + 1, 50);
        rst = 1'b1;
        tick();
        src_q[3].delete();
        exp_q[3].delete();
        order_q.push_back(1);
        order_q.push_back(3);
        push_pkt(1, 8'h41, 2);
        push_pkt(3, 8'h35, 2);
        @(negedge clk);
        chk("mid_rst_grant", 32'(grant_out), 32'd0);
        chk("mid_rst_read_out", 32'(read_out), 32'hF);
        chk("mid_rst_sw_enable_out", 32'(sw_enable_out), 32'd0);
        chk("mid_rst_pkt_abort", 32'(pkt_abort), 32'd0);
        tick();
        rst = 1'b0;
        wait_idle("after_rst", 100);
        chk("rst_no_abort", 32'(abort_cnt), 32'd1);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
